// File: rtl/hssi_ets_ts_pkg.sv
// Shared constants and helpers for the multi-channel ETS timestamp mux adapter.
package hssi_ets_ts_pkg;
  localparam int TS_WIDTH     = 96;
  localparam int FP_OUT_WIDTH = 32;
  localparam int DROP_CNT_W   = 16;

  // Channel ID width; a single channel still needs a 1-bit ID field.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hssi_ets_ts_fifo.sv
// Single-clock per-channel FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module hssi_ets_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             accept
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/hssi_ets_ts_mux_adapter.sv
// Multi-channel ETS timestamp adapter: per-channel FIFOs, round-robin arbiter, AVST output.
// Optional per-channel saturating drop counters under HSSI_ETS_TS_DROP_CNT_EN.
module hssi_ets_ts_mux_adapter
  import hssi_ets_ts_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  FP_WIDTH   = 8,
  parameter int  FIFO_DEPTH = 4,
  localparam int CH_W       = ch_width(NUM_CH),
  localparam int EW         = FP_WIDTH + TS_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         timestamp_fp_valid,
  input  logic [NUM_CH*EW-1:0]      timestamp_fp_data,
  output logic                      aso_timestamp_fp_valid,
  input  logic                      aso_timestamp_ready,
  output logic [TS_WIDTH-1:0]       aso_timestamp_data,
  output logic [FP_OUT_WIDTH-1:0]   aso_timestamp_fp,
  output logic [CH_W-1:0]           aso_timestamp_channel,
  output logic [NUM_CH-1:0]         ovf_sticky,
`ifdef HSSI_ETS_TS_DROP_CNT_EN
  output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt,
`endif
  input  logic [NUM_CH-1:0]         ovf_clr
);
  logic [NUM_CH-1:0][EW-1:0] fifo_q;
  logic [NUM_CH-1:0]         fifo_empty, fifo_full, fifo_accept, pop, drop;
  logic [CH_W-1:0]           ptr, grant, ptr_nxt;
  logic                      load;
  logic [EW-1:0]             sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hssi_ets_ts_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
      .clk    (clk),
      .rst    (reset),
      .push   (timestamp_fp_valid[i]),
      .pop    (pop[i]),
      .wdata  (timestamp_fp_data[i*EW +: EW]),
      .rdata  (fifo_q[i]),
      .full   (fifo_full[i]),
      .empty  (fifo_empty[i]),
      .accept (fifo_accept[i])
    );
  end

  assign drop = timestamp_fp_valid & ~fifo_accept;

  // Scan from the farthest slot back to ptr so the nearest non-empty channel wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!fifo_empty[idx]) grant = CH_W'(idx);
    end
    load    = (!aso_timestamp_fp_valid || aso_timestamp_ready) && !(&fifo_empty);
    pop     = '0;
    if (load) pop[grant] = 1'b1;
    ptr_nxt = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    sel     = fifo_q[grant];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr                    <= '0;
      aso_timestamp_fp_valid <= 1'b0;
      aso_timestamp_data     <= '0;
      aso_timestamp_fp       <= '0;
      aso_timestamp_channel  <= '0;
    end else if (load) begin
      ptr                    <= ptr_nxt;
      aso_timestamp_fp_valid <= 1'b1;
      aso_timestamp_data     <= sel[TS_WIDTH-1:0];
      aso_timestamp_fp       <= FP_OUT_WIDTH'(sel[EW-1:TS_WIDTH]);
      aso_timestamp_channel  <= grant;
    end else if (aso_timestamp_ready) begin
      aso_timestamp_fp_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_sticky <= '0;
    else       ovf_sticky <= (ovf_sticky & ~ovf_clr) | drop;
  end

`ifdef HSSI_ETS_TS_DROP_CNT_EN
  logic [NUM_CH-1:0][DROP_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ovf_clr[i])                       cnt[i] <= '0;
        else if (drop[i] && (cnt[i] != '1))   cnt[i] <= cnt[i] + DROP_CNT_W'(1);
      end
    end
  end

  assign drop_cnt = cnt;
`endif
endmodule

// File: tb/tb_hssi_ets_ts_mux_adapter.sv
// Bench for hssi_ets_ts_mux_adapter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hssi_ets_ts_mux_adapter;
  localparam int NUM_CH = 4;
  localparam int FPW    = 8;
  localparam int DEPTH  = 4;
  localparam int EW     = FPW + 96;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_CH-1:0]      vin = '0;
  logic [NUM_CH-1:0]      clr = '0;
  logic [NUM_CH*EW-1:0]   din = '0;
  logic                   ready = 1'b1;
  logic                   ovalid;
  logic [95:0]            odata;
  logic [31:0]            ofp;
  logic [1:0]             och;
  logic [NUM_CH-1:0]      ostk;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hssi_ets_ts_mux_adapter #(.NUM_CH(NUM_CH), .FP_WIDTH(FPW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset                  (rst),
    .timestamp_fp_valid     (vin),
    .timestamp_fp_data      (din),
    .aso_timestamp_fp_valid (ovalid),
    .aso_timestamp_ready    (ready),
    .aso_timestamp_data     (odata),
    .aso_timestamp_fp       (ofp),
    .aso_timestamp_channel  (och),
    .ovf_sticky             (ostk),
    .ovf_clr                (clr)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [95:0] ts, input logic [7:0] fp);
    din[i*EW +: EW] = {fp, ts};
  endtask

  // Reference model: per-channel queues of bounded size, a round-robin pointer
  // and a single output slot with hold-on-stall semantics.
  logic [EW-1:0] mq [NUM_CH][$];
  bit            m_vld;
  logic [95:0]   m_ts;
  logic [31:0]   m_fp;
  int            m_ch, m_ptr;
  logic [3:0]    m_stk;

  always @(posedge clk or posedge rst) begin : model_b
    int            g, idx, total;
    bit            ld;
    logic [EW-1:0] e;
    logic [3:0]    dropped;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_vld = 0; m_ts = '0; m_fp = '0; m_ch = 0; m_ptr = 0; m_stk = '0;
    end else begin
      total = 0;
      for (int i = 0; i < NUM_CH; i++) total += mq[i].size();
      ld = (!m_vld || ready) && (total > 0);
      g = -1;
      e = '0;
      if (ld) begin
        for (int k = 0; k < NUM_CH; k++) begin
          idx = (m_ptr + k) % NUM_CH;
          if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        e = mq[g].pop_front();
      end
      dropped = '0;
      for (int i = 0; i < NUM_CH; i++)
        if (vin[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(din[i*EW +: EW]);
          else dropped[i] = 1'b1;
        end
      for (int i = 0; i < NUM_CH; i++)
        if (dropped[i]) m_stk[i] = 1'b1;
        else if (clr[i]) m_stk[i] = 1'b0;
      if (ld) begin
        m_vld = 1; m_ts = e[95:0]; m_fp = {24'h0, e[EW-1:96]};
        m_ch = g; m_ptr = (g + 1) % NUM_CH;
      end else if (ready) begin
        m_vld = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mdl_valid", ovalid, m_vld);
      if (m_vld) begin
        chk("mdl_ts", odata, m_ts);
        chk("mdl_fp", ofp, m_fp);
        chk("mdl_ch", och, m_ch);
      end
      chk("mdl_sticky", ostk, m_stk);
    end
  end

  task automatic burst4(input logic [95:0] base, input int e0, input int e1, input int e2,
                        input int e3, input string nm);
    int exp_ch[4];
    exp_ch = '{e0, e1, e2, e3};
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) set_ch(i, base + 96'(i), 8'(i));
    vin = 4'hF;
    @(negedge clk);
    vin = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({nm, "_valid"}, ovalid, 1);
      chk({nm, "_ch"}, och, exp_ch[k]);
      chk({nm, "_ts"}, odata, base + 96'(exp_ch[k]));
    end
  endtask

  // Ready is held high; every valid seen at a falling edge is accepted next edge.
  task automatic drain(input int base, input int n_exp, input string nm);
    int got;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (ovalid) begin
        chk({nm, "_ts"}, odata, 96'(base + got));
        got++;
      end
      @(negedge clk);
      vin = '0;
    end
    chk({nm, "_count"}, got, n_exp);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", ovalid, 0);
    chk("rst_data", odata, 0);
    chk("rst_fp", ofp, 0);
    chk("rst_ch", och, 0);
    chk("rst_sticky", ostk, 0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin from reset, then with the pointer advanced to 1.
    burst4(96'h1000, 0, 1, 2, 3, "rr0");
    @(negedge clk);
    set_ch(0, 96'h55, 8'h01);
    vin = 4'b0001;
    @(negedge clk);
    vin = '0;
    repeat (3) @(negedge clk);
    burst4(96'h2000, 1, 2, 3, 0, "rr1");
    repeat (2) @(negedge clk);

    // Single entry on channel 2: two-cycle latency, one-cycle output.
    set_ch(2, 96'h0123_4567_89AB_CDEF_0011_2233, 8'hA5);
    vin = 4'b0100;
    @(negedge clk);
    vin = '0;
    chk("single_early", ovalid, 0);
    @(negedge clk);
    chk("single_valid", ovalid, 1);
    chk("single_ch", och, 2);
    chk("single_fp", ofp, 32'h0000_00A5);
    chk("single_ts", odata, 96'h0123_4567_89AB_CDEF_0011_2233);
    @(negedge clk);
    chk("single_once", ovalid, 0);

    // Backpressure: 10 entries into ch0 with ready low, 5 survive.
    @(negedge clk);
    ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_ch(0, 96'(100 + k), 8'(8'h10 + k));
      vin = 4'b0001;
      @(negedge clk);
    end
    vin = '0;
    chk("bp_hold_ts", odata, 100);
    chk("bp_sticky", ostk[0], 1);
    @(negedge clk);
    chk("bp_hold_ts2", odata, 100);
    chk("bp_hold_valid", ovalid, 1);
    ready = 1'b1;
    drain(100, 5, "bp");
    clr = 4'b0001;
    @(negedge clk);
    clr = '0;
    chk("bp_clr", ostk[0], 0);

    // Clear racing a drop on ch1 keeps the flag; a lone clear drops it.
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_ch(1, 96'(200 + k), 8'h20);
      vin = 4'b0010;
      @(negedge clk);
    end
    set_ch(1, 96'(205), 8'h20);
    vin = 4'b0010;
    clr = 4'b0010;
    @(negedge clk);
    vin = '0;
    clr = '0;
    chk("race_set", ostk[1], 1);
    clr = 4'b0010;
    @(negedge clk);
    clr = '0;
    chk("race_clr", ostk[1], 0);
    ready = 1'b1;
    drain(200, 5, "race");

    // Push into a full FIFO in the same cycle it pops.
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 96'(300 + k), 8'h30);
      vin = 4'b0001;
      @(negedge clk);
    end
    ready = 1'b1;
    set_ch(0, 96'(305), 8'h30);
    vin = 4'b0001;
    drain(300, 6, "pp");
    chk("pp_nodrop", ostk[0], 0);

    // Async reset with ch1 entries buffered; pointer must restart at 0.
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ch(1, 96'(400 + k), 8'h40);
      vin = 4'b0010;
      @(negedge clk);
    end
    vin = '0;
    @(negedge clk);
    chk("pre_rst_valid", ovalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", ovalid, 0);
    chk("rst_mid_data", odata, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_stale", ovalid, 0);
    end
    burst4(96'h5000, 0, 1, 2, 3, "rst_rr");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hssi_ets_ts_mux_adapter.md
Name: hssi_ets_ts_mux_adapter

Overview:
- Multi-channel successor to the single-channel ETS timestamp adapter.
- Captures 96-bit timestamp + fingerprint returns from NUM_CH HSSI ports. Each port's valid-only stream has no backpressure.
- Buffers each channel in a small FIFO, then round-robin arbitrates onto one AVST source with ready backpressure. Output is tagged with the channel ID.
- Sits between the HSSI subsystem timestamp outputs and the PTP/DMA timestamp consumer.

Parameters:
- NUM_CH, 4, number of timestamp channels (1..16).
- FP_WIDTH, 8, fingerprint width per channel (1..32).
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, 2..32.
- CH_W, $clog2(NUM_CH) with minimum 1, channel ID width (derived, not overridden).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- timestamp_fp_valid  in  NUM_CH  per-channel strobe; no backpressure.
- timestamp_fp_data  in  NUM_CH*(FP_WIDTH+96)  channel i occupies slice [i*(FP_WIDTH+96) +: FP_WIDTH+96]; within a slice, [95:0] is the timestamp and the upper FP_WIDTH bits are the fingerprint.
- aso_timestamp_fp_valid  out  1  AVST valid.
- aso_timestamp_ready  in  1  AVST ready, readyLatency 0.
- aso_timestamp_data  out  96  timestamp.
- aso_timestamp_fp  out  32  fingerprint, zero-extended.
- aso_timestamp_channel  out  CH_W  source channel.
- ovf_sticky  out  NUM_CH  per-channel drop flag.
- ovf_clr  in  NUM_CH  per-bit clear pulse.

Behaviour:
- Reset values (async, active-high): all FIFOs empty; arbiter pointer = 0; aso_timestamp_fp_valid = 0; aso_timestamp_data, aso_timestamp_fp, aso_timestamp_channel = 0; ovf_sticky = 0.
- Reset mid-operation: all buffered entries are discarded and the output deasserts immediately.
- Write: when timestamp_fp_valid[i] = 1, the entry is pushed into FIFO i at the clock edge if the FIFO is not full, or if it is full but popped in the same cycle.
- Overflow: otherwise the new entry is dropped, existing contents are kept, and ovf_sticky[i] sets.
- Sticky clear: ovf_clr[i] clears ovf_sticky[i] on the next edge. A simultaneous set and clear leaves the bit set.
- Output register: one stage, loaded when (!aso_timestamp_fp_valid || aso_timestamp_ready) and at least one FIFO is non-empty.
- Arbitration: grant goes to the first non-empty channel at or after the pointer, with modulo-NUM_CH wrap. On grant, that FIFO pops and the pointer moves to grant+1 (wrapping NUM_CH-1 -> 0).
- AVST hold: while valid && !ready, data, fp and channel are held stable. No pop occurs.
- Back-to-back: with ready held at 1, one entry is delivered per cycle.
- Latency: a valid input in cycle c appears at the output in cycle c+2 when the FIFO is empty and the output is idle or accepted. A FIFO bypass path is not permitted.
- Width rules:
  - aso_timestamp_fp = zero-extension of the fingerprint to 32 bits.
  - aso_timestamp_data = slice bits [95:0] of the granted entry.
- Ordering: per-channel order is preserved. No ordering is guaranteed across channels.
- NUM_CH = 1: the arbiter degenerates, and aso_timestamp_channel is constant 0.

Optional Feature:
- Macro: HSSI_ETS_TS_DROP_CNT_EN.
- With the macro defined:
  - Adds output port drop_cnt, NUM_CH*16 bits.
  - Each 16-bit per-channel counter increments on every dropped entry and saturates at 0xFFFF.
  - The counter clears to 0 on ovf_clr[i]. Clear wins over a same-cycle increment.
- Without the macro: the port and counters are absent. Only ovf_sticky exists.

Decomposition:
- Package hssi_ets_ts_pkg holds:
  - the TS_WIDTH = 96 and FP_OUT_WIDTH = 32 constants;
  - the drop-counter width (16);
  - a function returning the channel ID width with minimum 1.
- One sub-module, hssi_ets_ts_fifo: single-clock, parametrised depth/width. It provides push/pop, full/empty and a simultaneous push-pop-on-full accept. It is instantiated NUM_CH times.
- The arbiter and output register stay in the top module.

Test Plan:
- Single entry: ch2 valid with ts = 0x0123_4567_89AB_CDEF_0011_2233 and fp = 0xA5, ready = 1 → output valid 2 cycles later with channel = 2, fp = 0x0000_00A5 and the same ts, for exactly one cycle.
- Round-robin: all 4 channels valid in the same cycle, ready = 1 → outputs on 4 consecutive cycles in channel order 0, 1, 2, 3. A repeat burst starting with the pointer at 1 gives 1, 2, 3, 0.
- Backpressure: ready = 0 for 10 cycles while ch0 is valid every cycle with DEPTH = 4 → output holds the first entry stable. The FIFO holds 4 more, the remaining 5 are dropped, and ovf_sticky[0] = 1. After ready = 1, exactly 5 entries emerge in order.
- Overflow clear race: ovf_clr[1] pulsed in the same cycle as a ch1 drop → ovf_sticky[1] remains 1. A clear with no drop → 0 next cycle.
- Push-pop on full: FIFO0 full and ready = 1, with ch0 valid in the same cycle as a pop → new entry accepted, no drop, ovf_sticky[0] stays 0.
- Reset: async reset asserted mid-burst with 3 entries buffered → valid = 0 immediately. After release, no stale entries are output and the arbiter pointer restarts at channel 0.
